clahe_hist_accum: RTL and testbench
===================================

CLAHE_HIST_ACCUM -- requirements
Module: clahe_hist_accum

Interface
REQ-001 SHALL have parameter PIX_CNT_W, default 20, width of the per-frame accepted-pixel counter.
REQ-002 SHALL have port pclk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port frame_start  input  1  one-cycle pulse that arms accumulation for a new frame.
REQ-005 SHALL have port frame_end  input  1  one-cycle pulse marking the last pixel cycle of the frame.
REQ-006 SHALL have port clear_done  input  1  histogram RAM bank cleared and writable.
REQ-007 SHALL have port in_valid  input  1  pixel valid.
REQ-008 SHALL have port in_gray  input  8  pixel gray level, used as the bin address.
REQ-009 SHALL have port in_tile_idx  input  4  tile index of the pixel (0-15).
REQ-010 SHALL have port in_ready  output  1  block accepts pixels; a pixel is accepted when in_valid=1 and in_ready=1.
REQ-011 SHALL have port hist_rd_tile_idx  output  4  RAM read tile.
REQ-012 SHALL have port hist_rd_addr  output  8  RAM read bin.
REQ-013 SHALL have port hist_rd_data  input  16  RAM read data, valid one cycle after the address.
REQ-014 SHALL have port hist_wr_en  output  1  RAM write strobe.
REQ-015 SHALL have port hist_wr_tile_idx  output  4  RAM write tile.
REQ-016 SHALL have port hist_wr_addr  output  8  RAM write bin.
REQ-017 SHALL have port hist_wr_data  output  16  new bin count.
REQ-018 SHALL have port hist_done  output  1  one-cycle pulse; the frame histogram is complete in RAM.
REQ-019 SHALL have port pix_cnt  output  PIX_CNT_W  number of pixels accepted in the current or last frame.

Function
REQ-020 SHALL implement the FSM states IDLE, WAIT_CLR, ACCUM, DRAIN and DONE; IDLE is the reset state.
REQ-021 SHALL, in IDLE, move to ACCUM on frame_start when clear_done=1, and to WAIT_CLR on frame_start when clear_done=0; frame_start SHALL clear pix_cnt to 0.
REQ-022 SHALL, in WAIT_CLR, move to ACCUM on the first cycle with clear_done=1.
REQ-023 SHALL drive in_ready=1 only in ACCUM; pixels offered in any other state SHALL be ignored and SHALL cause no RAM access.
REQ-024 SHALL, in ACCUM, accept a pixel in the same cycle as frame_end and then move to DRAIN.
REQ-025 SHALL, in DRAIN, stay exactly 3 cycles so the pipeline empties, then move to DONE.
REQ-026 SHALL, in DONE, assert hist_done for one cycle and return to IDLE.
REQ-027 SHALL ignore frame_start outside IDLE and frame_end outside ACCUM.
REQ-028 SHALL drive hist_rd_addr=in_gray and hist_rd_tile_idx=in_tile_idx combinationally at all times.
REQ-029 SHALL register each accepted pixel into stage S1 (valid, gray, tile); S1 SHALL compute base+1.
REQ-030 SHALL register the S1 result into S2, which drives hist_wr_* directly from registers; a pixel accepted at edge t SHALL therefore write at edge t+2.
REQ-031 SHALL copy S2 into S3 one cycle later to hold the write committed at the previous edge.
REQ-032 SHALL select base with the priority: S2 data when S2 is valid and tile and gray match; otherwise S3 data when S3 is valid and they match; otherwise hist_rd_data.
REQ-033 SHALL saturate the new count at 16'hFFFF with no wrap.
REQ-034 SHALL increment pix_cnt on each accepted pixel, wrapping modulo 2^PIX_CNT_W.
REQ-035 SHALL produce exactly one write per accepted pixel; back-to-back same-bin pixels SHALL yield strictly increasing counts.

Reset
REQ-036 SHALL, while rst=1, force the state to IDLE, all stage valids to 0, and in_ready, hist_wr_en, hist_done, hist_wr_tile_idx, hist_wr_addr, hist_wr_data and pix_cnt to 0.
REQ-037 SHALL, on reset during ACCUM or DRAIN, discard the in-flight pixels with no further writes; after rst deasserts, no writes SHALL occur until a new frame_start.

Verification
REQ-038 SHALL be verified for basic accumulation: bin initially 0, 4 consecutive pixels gray=0x37 tile=5 -> writes 1, 2, 3, 4 at tile 5 addr 0x37 on consecutive cycles, first write 2 cycles after the first accept.
REQ-039 SHALL be verified for the S3 forwarding path: pattern A, B, A with the same tile -> the second write of A is 2 even though the RAM read of A is in flight during the first write.
REQ-040 SHALL be verified for saturation: RAM returns 0xFFFE, three pixels to that bin -> writes 0xFFFF, 0xFFFF, 0xFFFF.
REQ-041 SHALL be verified for the clear wait: frame_start with clear_done=0 for 10 cycles -> in_ready=0 and hist_wr_en=0 throughout; in_ready rises the cycle after clear_done=1 is seen.
REQ-042 SHALL be verified for frame end: frame_end together with a valid pixel -> that pixel is written, hist_done pulses exactly once 4 cycles later, and pix_cnt equals the number of accepted pixels.
REQ-043 SHALL be verified for reset mid-frame: rst pulsed 1 cycle after 2 accepts -> hist_wr_en stays 0, state is IDLE, and pix_cnt=0.

Source files
------------

// File: rtl/clahe_hist_accum.sv
// rtl/clahe_hist_accum.sv - per-tile histogram accumulator with read-modify-write forwarding
module clahe_hist_accum #(
    parameter int PIX_CNT_W = 20
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 clear_done,
    input  logic                 in_valid,
    input  logic [7:0]           in_gray,
    input  logic [3:0]           in_tile_idx,
    output logic                 in_ready,
    output logic [3:0]           hist_rd_tile_idx,
    output logic [7:0]           hist_rd_addr,
    input  logic [15:0]          hist_rd_data,
    output logic                 hist_wr_en,
    output logic [3:0]           hist_wr_tile_idx,
    output logic [7:0]           hist_wr_addr,
    output logic [15:0]          hist_wr_data,
    output logic                 hist_done,
    output logic [PIX_CNT_W-1:0] pix_cnt
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_CLR = 3'd1;
    localparam logic [2:0] ACCUM    = 3'd2;
    localparam logic [2:0] DRAIN    = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]  state;
    logic [1:0]  drain_cnt;
    logic        accept;

    logic        s1_valid;
    logic [7:0]  s1_gray;
    logic [3:0]  s1_tile;
    logic [15:0] base;
    logic [15:0] s1_count;

    logic        s3_valid;
    logic [7:0]  s3_gray;
    logic [3:0]  s3_tile;
    logic [15:0] s3_data;

    assign in_ready         = (state == ACCUM);
    assign hist_done        = (state == DONE);
    assign accept           = in_valid & in_ready;
    assign hist_rd_addr     = in_gray;
    assign hist_rd_tile_idx = in_tile_idx;

    // S2 holds a write not yet in RAM; S3 holds the write the RAM read may have missed.
    always_comb begin
        base = hist_rd_data;
        if (hist_wr_en && hist_wr_tile_idx == s1_tile && hist_wr_addr == s1_gray)
            base = hist_wr_data;
        else if (s3_valid && s3_tile == s1_tile && s3_gray == s1_gray)
            base = s3_data;
        s1_count = (base == 16'hFFFF) ? base : base + 16'd1;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start)
                        state <= clear_done ? ACCUM : WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (clear_done)
                        state <= ACCUM;
                end
                ACCUM: begin
                    drain_cnt <= 2'd0;
                    if (frame_end)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2)
                        state <= DONE;
                    else
                        drain_cnt <= drain_cnt + 2'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (state == IDLE && frame_start) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s1_gray          <= 8'd0;
            s1_tile          <= 4'd0;
            hist_wr_en       <= 1'b0;
            hist_wr_tile_idx <= 4'd0;
            hist_wr_addr     <= 8'd0;
            hist_wr_data     <= 16'd0;
            s3_valid         <= 1'b0;
            s3_gray          <= 8'd0;
            s3_tile          <= 4'd0;
            s3_data          <= 16'd0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_gray <= in_gray;
                s1_tile <= in_tile_idx;
            end
            hist_wr_en <= s1_valid;
            if (s1_valid) begin
                hist_wr_tile_idx <= s1_tile;
                hist_wr_addr     <= s1_gray;
                hist_wr_data     <= s1_count;
            end
            s3_valid <= hist_wr_en;
            if (hist_wr_en) begin
                s3_gray <= hist_wr_addr;
                s3_tile <= hist_wr_tile_idx;
                s3_data <= hist_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_clahe_hist_accum.sv
// tb/tb_clahe_hist_accum.sv - scoreboard bench for clahe_hist_accum
module tb_clahe_hist_accum;

    logic        pclk = 1'b0;
    logic        rst;
    logic        frame_start, frame_end, clear_done, in_valid;
    logic [7:0]  in_gray;
    logic [3:0]  in_tile_idx;
    logic        in_ready;
    logic [3:0]  hist_rd_tile_idx;
    logic [7:0]  hist_rd_addr;
    logic [15:0] hist_rd_data;
    logic        hist_wr_en;
    logic [3:0]  hist_wr_tile_idx;
    logic [7:0]  hist_wr_addr;
    logic [15:0] hist_wr_data;
    logic        hist_done;
    logic [19:0] pix_cnt;

    clahe_hist_accum #(.PIX_CNT_W(20)) dut (
        .pclk(pclk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .clear_done(clear_done), .in_valid(in_valid), .in_gray(in_gray),
        .in_tile_idx(in_tile_idx), .in_ready(in_ready),
        .hist_rd_tile_idx(hist_rd_tile_idx), .hist_rd_addr(hist_rd_addr),
        .hist_rd_data(hist_rd_data), .hist_wr_en(hist_wr_en),
        .hist_wr_tile_idx(hist_wr_tile_idx), .hist_wr_addr(hist_wr_addr),
        .hist_wr_data(hist_wr_data), .hist_done(hist_done), .pix_cnt(pix_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0]  t;
        logic [7:0]  g;
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          fe_cyc;
    logic        ram_init;
    logic [15:0] mem [16][256];

    always @(posedge pclk) cyc <= cyc + 1;

    // Read-before-write RAM, so a read colliding with a write returns the old count.
    always @(posedge pclk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 256; j++)
                    mem[i][j] <= 16'd0;
            mem[3][8'h80] <= 16'hFFFE;
        end else begin
            hist_rd_data <= mem[hist_rd_tile_idx][hist_rd_addr];
            if (hist_wr_en)
                mem[hist_wr_tile_idx][hist_wr_addr] <= hist_wr_data;
        end
    end

    always @(negedge pclk) begin
        if (hist_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: tile=%0d addr=%h data=%h at cyc %0d, none expected",
                         hist_wr_tile_idx, hist_wr_addr, hist_wr_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({hist_wr_tile_idx, hist_wr_addr, hist_wr_data} !== {e.t, e.g, e.d} || cyc != e.c) begin
                    errors++;
                    $display("FAIL write: got tile=%0d addr=%h data=%h cyc=%0d, want tile=%0d addr=%h data=%h cyc=%0d",
                             hist_wr_tile_idx, hist_wr_addr, hist_wr_data, cyc, e.t, e.g, e.d, e.c);
                end
            end
        end
        if (hist_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic px(input logic v, input logic [7:0] g, input logic [3:0] t,
                      input logic fe, input logic [15:0] d, input logic push);
        @(negedge pclk);
        in_valid    = v;
        in_gray     = g;
        in_tile_idx = t;
        frame_end   = fe;
        if (v && in_ready && push)
            exp_q.push_back('{t: t, g: g, d: d, c: cyc + 2});
    endtask

    task automatic fs();
        @(negedge pclk);
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        frame_start = 0; frame_end = 0; clear_done = 1; in_valid = 0;
        in_gray = 0; in_tile_idx = 0;
        repeat (3) @(negedge pclk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", hist_wr_en, 0);
        chk("rst_done", hist_done, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_wr_data", hist_wr_data, 0);
        chk("rst_wr_addr", {hist_wr_tile_idx, hist_wr_addr}, 0);
        rst = 1'b0; ram_init = 1'b0;

        fs();
        chk("accum_ready", in_ready, 1);
        chk("start_pix_cnt", pix_cnt, 0);

        px(1, 8'h37, 4'd5, 0, 16'd1, 1);
        #1 chk("rd_addr_comb", {hist_rd_tile_idx, hist_rd_addr}, {4'd5, 8'h37});
        px(1, 8'h37, 4'd5, 0, 16'd2, 1);
        px(1, 8'h37, 4'd5, 0, 16'd3, 1);
        px(1, 8'h37, 4'd5, 0, 16'd4, 1);
        px(1, 8'h10, 4'd2, 0, 16'd1, 1);
        px(1, 8'h20, 4'd2, 0, 16'd1, 1);
        px(1, 8'h10, 4'd2, 0, 16'd2, 1);
        px(1, 8'h80, 4'd3, 0, 16'hFFFF, 1);
        px(1, 8'h80, 4'd3, 0, 16'hFFFF, 1);
        px(1, 8'h80, 4'd3, 0, 16'hFFFF, 1);
        repeat (4) px(0, 8'h00, 4'd0, 0, 16'd0, 0);
        px(1, 8'h37, 4'd5, 0, 16'd5, 1);
        px(1, 8'h44, 4'd1, 1, 16'd1, 1);
        fe_cyc = cyc;
        repeat (6) px(0, 8'h00, 4'd0, 0, 16'd0, 0);
        chk("done_count", done_cnt, 1);
        chk("done_latency", done_cyc - fe_cyc, 4);
        chk("frame_pix_cnt", pix_cnt, 12);
        chk("idle_ready", in_ready, 0);
        repeat (3) px(1, 8'h55, 4'd0, 0, 16'd0, 0);
        px(0, 8'h00, 4'd0, 0, 16'd0, 0);

        clear_done = 1'b0;
        fs();
        chk("wait_pix_cnt", pix_cnt, 0);
        in_valid = 1'b1; in_gray = 8'h66; in_tile_idx = 4'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            chk("wait_ready", in_ready, 0);
            chk("wait_wr_en", hist_wr_en, 0);
        end
        in_valid = 1'b0;
        clear_done = 1'b1;
        chk("clr_seen_ready", in_ready, 0);
        @(negedge pclk);
        chk("clr_after_ready", in_ready, 1);

        px(1, 8'h01, 4'd9, 0, 16'd1, 1);
        px(1, 8'h02, 4'd9, 0, 16'd0, 0);
        @(negedge pclk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1 chk("rstmid_wr_en", hist_wr_en, 0);
        @(negedge pclk);
        chk("rstmid_pix_cnt", pix_cnt, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_gray = 8'h03; in_tile_idx = 4'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("post_rst_ready", in_ready, 0);
            chk("post_rst_wr_en", hist_wr_en, 0);
        end
        in_valid = 1'b0;
        chk("post_rst_pix_cnt", pix_cnt, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge pclk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
